vga_cpu_bridge: RTL and testbench
=================================

// Module: vga_cpu_bridge
// PURPOSE
//  Upstream stage of the VGA framebuffer controller.
//  - Samples the 6502 bus (CPU_CLK, CE, RWB, ADDR, DATA) into the pixel clock domain.
//  - Decodes writes to the 4-register draw interface and queues pixel-write commands {x,y,color} in a FIFO.
//  - Hands commands downstream over a valid/ready handshake, so no CPU write is lost while the framebuffer port is busy.
// PARAMETERS
//  DEPTH   16   FIFO entries; power of two, >= 2
//  PTR_W   4    log2(DEPTH)
//  X_MAX   199  largest legal x coordinate
//  Y_MAX   149  largest legal y coordinate
// PORTS
//  CLK       in   1  pixel clock; all logic on posedge
//  RESB      in   1  asynchronous active-low reset
//  CPU_CLK   in   1  6502 phi2, asynchronous to CLK
//  CE        in   1  chip enable, active-low
//  RWB       in   1  1 = read, 0 = write
//  ADDR      in   2  register select
//  DATA      in   8  CPU data bus (write-only block)
//  PX_X      out  8  command x coordinate
//  PX_Y      out  8  command y coordinate
//  PX_COLOR  out  3  command colour {B,G,R}
//  PX_VALID  out  1  command available at FIFO head
//  PX_READY  in   1  downstream accepts head this cycle
//  FULL      out  1  FIFO holds DEPTH entries
//  OVERFLOW  out  1  sticky: a DRAW was dropped because FIFO full
// BEHAVIOUR
//  - Reset (RESB=0, async): X/Y/COLOR regs=0, FIFO empty, PX_VALID=0, FULL=0, OVERFLOW=0.
//    PX_X/PX_Y/PX_COLOR=0. Sync flops cleared with CPU_CLK stage=1. Reset mid-burst discards queued commands.
//  - Sync: CPU_CLK through 3 flops (s1,s2,s3). CE, RWB, ADDR, DATA through 2 flops.
//  - Commit pulse: one CLK, when s3=1, s2=0 (phi2 falling) AND synced CE=0 AND synced RWB=0.
//  - Latency: commit occurs 3 CLK edges after phi2 falls.
//  - Register map on commit:
//    - 0: X_REG <= DATA
//    - 1: Y_REG <= DATA
//    - 2: COL_REG <= DATA[2:0]
//    - 3: DRAW; DATA ignored; push {X_REG, Y_REG, COL_REG}
//  - Range check: DRAW with X_REG>X_MAX or Y_REG>Y_MAX is discarded silently. No push, no OVERFLOW.
//  - Push when DRAW is legal and (count<DEPTH or a pop occurs the same cycle).
//    Otherwise drop and set OVERFLOW=1, held until reset.
//  - Pop when PX_VALID & PX_READY.
//  - Simultaneous push+pop: count unchanged; both pointers advance.
//  - Pointers PTR_W bits, wrap DEPTH-1 -> 0. count is PTR_W+1 bits.
//  - PX_VALID = (count!=0). PX_X/PX_Y/PX_COLOR show the head entry; held stable while PX_VALID & ~PX_READY.
//  - First-word latency: push at edge n -> PX_VALID=1 after edge n; downstream may accept at edge n+1.
//  - FULL = (count==DEPTH), registered with count.
//  - Reads (RWB=1) and CE=1 cycles: no effect.
// CONFIGURATION
//  VGA_CPU_BRIDGE_AUTOINC_EN:
//  - Defined: after every accepted DRAW, X_REG increments.
//    - If X_REG==X_MAX: X_REG<=0 and Y_REG<=Y_REG+1.
//    - If Y_REG==Y_MAX on that wrap: Y_REG<=0.
//    - A discarded or dropped DRAW does not increment.
//  - Undefined: X_REG and Y_REG change only on writes to addresses 0 and 1.
// TESTING
//  1 Reset: hold RESB=0 during bus activity -> all outputs 0. Release, idle 10 CLK -> PX_VALID stays 0.
//  2 Single draw: write X=10, Y=20, COL=5, then DRAW; PX_READY=1 ->
//    one PX_VALID pulse with PX_X=10, PX_Y=20, PX_COLOR=5, exactly 1 entry.
//  3 Fill/overflow: PX_READY=0, issue 17 DRAWs ->
//    FULL=1 after the 16th, OVERFLOW=1 after the 17th.
//    PX_READY=1 -> 16 entries drained in order; FULL=0 after the first pop; OVERFLOW stays 1.
//  4 Range/bus filter:
//    - X=200, Y=0, DRAW -> no PX_VALID and OVERFLOW=0.
//    - Write with CE=1, or read with RWB=1, at addr 0 -> X_REG unchanged.
//  5 Push+pop at full: FIFO full, PX_READY=1 on the cycle a DRAW commits ->
//    entry accepted, count stays 16, OVERFLOW=0.
//  6 AUTOINC_EN: X=198, Y=149, three DRAWs -> coordinates (198,149), (199,149), (0,0).
//    With the macro undefined -> (198,149) three times.

Source files
------------

// File: rtl/vga_cpu_bridge.sv
// 6502 draw-register front end: syncs the CPU bus into CLK, decodes the X/Y/COLOR/DRAW registers, queues pixel commands.
// Optional VGA_CPU_BRIDGE_AUTOINC_EN: advance X (wrapping into Y) after every accepted DRAW.
module vga_cpu_bridge #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int X_MAX = 199,
    parameter int Y_MAX = 149
) (
    input  logic       CLK,
    input  logic       RESB,
    input  logic       CPU_CLK,
    input  logic       CE,
    input  logic       RWB,
    input  logic [1:0] ADDR,
    input  logic [7:0] DATA,
    output logic [7:0] PX_X,
    output logic [7:0] PX_Y,
    output logic [2:0] PX_COLOR,
    output logic       PX_VALID,
    input  logic       PX_READY,
    output logic       FULL,
    output logic       OVERFLOW
);

    typedef enum logic [1:0] {
        REG_X    = 2'd0,
        REG_Y    = 2'd1,
        REG_COL  = 2'd2,
        REG_DRAW = 2'd3
    } reg_sel_t;

    localparam logic [7:0]       X_LIM    = 8'(X_MAX);
    localparam logic [7:0]       Y_LIM    = 8'(Y_MAX);
    localparam logic [PTR_W:0]   DEPTH_N  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // bus synchronisers
    logic       cpu_clk_s1, cpu_clk_s2, cpu_clk_s3;
    logic       ce_s1, ce_s2;
    logic       rwb_s1, rwb_s2;
    logic [1:0] addr_s1;
    reg_sel_t   addr_s2;
    logic [7:0] data_s1, data_s2;

    // draw registers
    logic [7:0] x_reg, y_reg;
    logic [2:0] col_reg;

    // command FIFO
    logic [18:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic [18:0]      head;

    logic commit, draw, in_range, push, pop, drop;

    // CPU_CLK stages reset high so no false phi2 fall is seen on reset release
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            cpu_clk_s1 <= 1'b1;
            cpu_clk_s2 <= 1'b1;
            cpu_clk_s3 <= 1'b1;
            ce_s1      <= 1'b1;
            ce_s2      <= 1'b1;
            rwb_s1     <= 1'b1;
            rwb_s2     <= 1'b1;
            addr_s1    <= '0;
            addr_s2    <= REG_X;
            data_s1    <= '0;
            data_s2    <= '0;
        end else begin
            cpu_clk_s1 <= CPU_CLK;
            cpu_clk_s2 <= cpu_clk_s1;
            cpu_clk_s3 <= cpu_clk_s2;
            ce_s1      <= CE;
            ce_s2      <= ce_s1;
            rwb_s1     <= RWB;
            rwb_s2     <= rwb_s1;
            addr_s1    <= ADDR;
            addr_s2    <= reg_sel_t'(addr_s1);
            data_s1    <= DATA;
            data_s2    <= data_s1;
        end
    end

    always_comb begin
        commit   = cpu_clk_s3 & ~cpu_clk_s2 & ~ce_s2 & ~rwb_s2;
        draw     = commit && (addr_s2 == REG_DRAW);
        in_range = (x_reg <= X_LIM) && (y_reg <= Y_LIM);
        pop      = PX_VALID & PX_READY;
        // a full FIFO still accepts when the head leaves on the same edge
        push     = draw & in_range & ((count != DEPTH_N) | pop);
        drop     = draw & in_range & ~push;

        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            x_reg   <= '0;
            y_reg   <= '0;
            col_reg <= '0;
        end else if (commit) begin
            unique case (addr_s2)
                REG_X:   x_reg   <= data_s2;
                REG_Y:   y_reg   <= data_s2;
                REG_COL: col_reg <= data_s2[2:0];
                REG_DRAW: begin
`ifdef VGA_CPU_BRIDGE_AUTOINC_EN
                    if (push) begin
                        if (x_reg == X_LIM) begin
                            x_reg <= '0;
                            y_reg <= (y_reg == Y_LIM) ? '0 : y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_next;
            FULL  <= (count_next == DEPTH_N);
            if (drop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {x_reg, y_reg, col_reg};
        end
    end

    // head is forced to zero when empty so outputs read 0 after reset
    always_comb begin
        head     = mem[rd_ptr];
        PX_VALID = (count != '0);
        PX_X     = PX_VALID ? head[18:11] : '0;
        PX_Y     = PX_VALID ? head[10:3]  : '0;
        PX_COLOR = PX_VALID ? head[2:0]   : '0;
    end

endmodule

// File: tb/tb_vga_cpu_bridge.sv
// Bench for vga_cpu_bridge: queue-based reference model, per-cycle compare, directed scenarios plus random bus traffic.
module tb_vga_cpu_bridge;

    localparam int DEPTH = 16;
    localparam int XM    = 199;
    localparam int YM    = 149;

    logic       CLK = 1'b0;
    logic       RESB = 1'b0;
    logic       CPU_CLK = 1'b0;
    logic       CE = 1'b1;
    logic       RWB = 1'b1;
    logic [1:0] ADDR = '0;
    logic [7:0] DATA = '0;
    logic [7:0] PX_X, PX_Y;
    logic [2:0] PX_COLOR;
    logic       PX_VALID, FULL, OVERFLOW;
    logic       PX_READY;

    vga_cpu_bridge #(.DEPTH(DEPTH), .PTR_W(4), .X_MAX(XM), .Y_MAX(YM)) dut (
        .CLK(CLK), .RESB(RESB), .CPU_CLK(CPU_CLK), .CE(CE), .RWB(RWB),
        .ADDR(ADDR), .DATA(DATA), .PX_X(PX_X), .PX_Y(PX_Y), .PX_COLOR(PX_COLOR),
        .PX_VALID(PX_VALID), .PX_READY(PX_READY), .FULL(FULL), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // downstream ready: fixed level or random, applied just after each falling CLK edge
    bit ready_val  = 1'b0;
    bit rand_ready = 1'b0;
    initial begin
        PX_READY = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            PX_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } cmd_t;

    // reference model: phi2 fall seen at one CLK edge commits two edges later with the bus seen then
    cmd_t       mq[$];
    logic [7:0] mx, my;
    logic [2:0] mc;
    bit         movf;
    bit         prev_cpu;
    int         pcd;
    logic [1:0] pa;
    logic [7:0] pd;

    always @(posedge CLK or negedge RESB) begin
        bit   mpop, mpush;
        cmd_t e;
        if (!RESB) begin
            mq.delete();
            mx = 0; my = 0; mc = 0;
            movf = 0; prev_cpu = 1; pcd = 0;
        end else begin
            mpop  = (mq.size() != 0) && PX_READY;
            mpush = 0;
            e     = '0;
            if (pcd > 0) begin
                pcd--;
                if (pcd == 0) begin
                    case (pa)
                        2'd0: mx = pd;
                        2'd1: my = pd;
                        2'd2: mc = pd[2:0];
                        default: begin
                            if (mx <= XM && my <= YM) begin
                                if (mq.size() < DEPTH || mpop) begin
                                    mpush = 1;
                                    e = '{mx, my, mc};
`ifdef VGA_CPU_BRIDGE_AUTOINC_EN
                                    if (mx == XM) begin
                                        mx = 0;
                                        my = (my == YM) ? 8'd0 : my + 8'd1;
                                    end else begin
                                        mx = mx + 8'd1;
                                    end
`endif
                                end else begin
                                    movf = 1;
                                end
                            end
                        end
                    endcase
                end
            end
            if (prev_cpu && !CPU_CLK && !CE && !RWB) begin
                pcd = 2; pa = ADDR; pd = DATA;
            end
            prev_cpu = CPU_CLK;
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back(e);
        end
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge CLK);
        check("px_valid", PX_VALID, (mq.size() != 0));
        check("full", FULL, (mq.size() == DEPTH));
        check("overflow", OVERFLOW, movf);
        if (mq.size() != 0) begin
            check("px_x", PX_X, mq[0].x);
            check("px_y", PX_Y, mq[0].y);
            check("px_color", PX_COLOR, mq[0].c);
        end
    end

    // records every accepted head (handshake will complete at the next rising edge)
    int   pops = 0;
    cmd_t popped[$];
    initial forever begin
        @(negedge CLK);
        #2;
        if (RESB && PX_VALID && PX_READY) begin
            pops++;
            popped.push_back({PX_X, PX_Y, PX_COLOR});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=2000000");
        $fatal(1);
    end

    task automatic bus(input logic [1:0] a, input logic [7:0] d, input logic ce,
                       input logic rwb, input bit pop_at_commit = 1'b0);
        @(negedge CLK);
        ADDR = a; DATA = d; CE = ce; RWB = rwb; CPU_CLK = 1'b1;
        repeat (3) @(negedge CLK);
        CPU_CLK = 1'b0;
        repeat (2) @(negedge CLK);
        if (pop_at_commit) ready_val = 1'b1;
        @(negedge CLK);
        if (pop_at_commit) ready_val = 1'b0;
        @(negedge CLK);
        CE = 1'b1; RWB = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus(a, d, 1'b0, 1'b0);
    endtask

    task automatic draw();
        bus(2'd3, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        ready_val = 1'b0;
        rand_ready = 1'b0;
        @(negedge CLK);
        #3 RESB = 1'b0;
        repeat (3) @(negedge CLK);
        #3 RESB = 1'b1;
        @(negedge CLK);
    endtask

    task automatic drain();
        ready_val = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!PX_VALID && mq.size() == 0) break;
        end
        check("drain_done", PX_VALID, 0);
    endtask

    initial begin
        // reset held across bus activity
        wr(2'd0, 8'd55);
        draw();
        check("rst_valid", PX_VALID, 0);
        check("rst_x", PX_X, 0);
        check("rst_y", PX_Y, 0);
        check("rst_color", PX_COLOR, 0);
        check("rst_full", FULL, 0);
        check("rst_overflow", OVERFLOW, 0);
        @(negedge CLK);
        #3 RESB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_valid", PX_VALID, 0);
        end

        // single draw
        ready_val = 1'b1;
        pops = 0; popped.delete();
        wr(2'd0, 8'd10); wr(2'd1, 8'd20); wr(2'd2, 8'd5);
        draw();
        repeat (5) @(negedge CLK);
        check("single_pops", pops, 1);
        if (popped.size() > 0) begin
            check("single_x", popped[0].x, 10);
            check("single_y", popped[0].y, 20);
            check("single_color", popped[0].c, 5);
        end

        // fill and overflow
        do_reset();
        wr(2'd0, 8'd30); wr(2'd1, 8'd40); wr(2'd2, 8'd3);
        for (int i = 1; i <= 17; i++) begin
            draw();
            if (i == 16) begin
                check("fill_full16", FULL, 1);
                check("fill_ovf16", OVERFLOW, 0);
            end
            if (i == 17) begin
                check("fill_full17", FULL, 1);
                check("fill_ovf17", OVERFLOW, 1);
            end
        end
        pops = 0; popped.delete();
        ready_val = 1'b1;
        repeat (2) @(negedge CLK);
        check("fill_full_after_pop", FULL, 0);
        drain();
        check("fill_pops", pops, 16);
        check("fill_ovf_sticky", OVERFLOW, 1);
        if (popped.size() > 0) check("fill_first_x", popped[0].x, 30);

        // range and bus filtering
        do_reset();
        ready_val = 1'b1;
        pops = 0; popped.delete();
        wr(2'd0, 8'd200); wr(2'd1, 8'd0);
        draw();
        repeat (3) @(negedge CLK);
        check("range_pops", pops, 0);
        check("range_valid", PX_VALID, 0);
        check("range_ovf", OVERFLOW, 0);
        wr(2'd0, 8'd5);
        bus(2'd0, 8'd77, 1'b1, 1'b0);
        bus(2'd0, 8'd88, 1'b0, 1'b1);
        wr(2'd1, 8'd1);
        draw();
        repeat (5) @(negedge CLK);
        check("filter_pops", pops, 1);
        if (popped.size() > 0) check("filter_x", popped[0].x, 5);

        // push and pop on the same edge while full
        do_reset();
        pops = 0;
        wr(2'd0, 8'd1); wr(2'd1, 8'd2); wr(2'd2, 8'd6);
        for (int i = 0; i < 16; i++) draw();
        check("pp_full_before", FULL, 1);
        bus(2'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        check("pp_full_after", FULL, 1);
        check("pp_ovf", OVERFLOW, 0);
        check("pp_one_pop", pops, 1);
        drain();
        check("pp_total_pops", pops, 17);

        // auto-increment wrap
        do_reset();
        wr(2'd0, 8'd198); wr(2'd1, 8'd149);
        repeat (3) draw();
        pops = 0; popped.delete();
        drain();
        check("ai_pops", pops, 3);
        if (popped.size() == 3) begin
            check("ai_x0", popped[0].x, 198);
            check("ai_y0", popped[0].y, 149);
`ifdef VGA_CPU_BRIDGE_AUTOINC_EN
            check("ai_x1", popped[1].x, 199);
            check("ai_y1", popped[1].y, 149);
            check("ai_x2", popped[2].x, 0);
            check("ai_y2", popped[2].y, 0);
`else
            check("ai_x1", popped[1].x, 198);
            check("ai_y1", popped[1].y, 149);
            check("ai_x2", popped[2].x, 198);
            check("ai_y2", popped[2].y, 149);
`endif
        end

        // random traffic with random backpressure, one mid-run reset
        do_reset();
        for (int i = 0; i < 260; i++) begin
            logic [1:0] a;
            logic [7:0] d;
            if (i == 130) do_reset();
            rand_ready = 1'b1;
            a = ($urandom_range(0, 2) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = 8'($urandom_range(0, 215));
                2'd1:    d = 8'($urandom_range(0, 165));
                default: d = 8'($urandom);
            endcase
            bus(a, d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        rand_ready = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
